// File: rtl/muldiv_controller.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one step per clock, sign fixed up at the end.
module muldiv_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;   // negate product / quotient
    logic               neg_r;   // negate remainder

    logic               signed_op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != IDLE);

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        sign_a    = signed_op & a[WIDTH-1];
        sign_b    = signed_op & b[WIDTH-1];
        mag_a     = sign_a ? -a : a;
        mag_b     = sign_b ? -b : b;

        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted   = acc[2*WIDTH-1:WIDTH-1];
        diff      = shifted - {1'b0, opnd};

        acc_next  = {add_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (diff[WIDTH])
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end

        prod_fix  = neg_q ? -acc : acc;
        quot_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc         <= {{WIDTH{1'b0}}, mag_b};
                                opnd        <= mag_a;
                                is_div      <= 1'b0;
                                neg_q       <= sign_a ^ sign_b;
                                neg_r       <= 1'b0;
                                cnt         <= '0;
                                div_by_zero <= 1'b0;
                                state       <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (b == '0) begin
                                    div_by_zero <= 1'b1;
                                    done        <= 1'b1;
                                end else begin
                                    acc         <= {{WIDTH{1'b0}}, mag_a};
                                    opnd        <= mag_b;
                                    is_div      <= 1'b1;
                                    neg_q       <= sign_a ^ sign_b;
                                    neg_r       <= sign_a;
                                    cnt         <= '0;
                                    div_by_zero <= 1'b0;
                                    state       <= RUN;
                                end
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: stimulus pushes expected HI/LO/flag,
// a negedge monitor pops and compares on every Done pulse.
module tb_muldiv_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic        model_dbz = 1'b0;

    muldiv_controller #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference results straight from integer arithmetic: {HI, LO}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy, res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        res = '0;
        case (o)
            3'd0: res = 64'(sx * sy);
            3'd1: res = ux * uy;
            3'd2: begin
                q = sx / sy;
                r = sx % sy;
                res = {r[31:0], q[31:0]};
            end
            3'd3: res = {32'(ux % uy), 32'(ux / uy)};
            default: res = '0;
        endcase
        return res;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
                check("result_dbz", 64'(div_by_zero), 64'(e.dbz));
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int intrude_at = 0, input int reset_at = 0);
        logic [63:0] r;
        exp_t        e;
        int          cyc;
        bit          dz, iter;
        dz   = ((o == 3'd2) || (o == 3'd3)) && (y == 32'd0);
        iter = (o <= 3'd3) && !dz;
        r    = model(o, x, y);
        if (iter && reset_at == 0) begin
            e.hi = r[63:32]; e.lo = r[31:0]; e.dbz = 1'b0;
            sb_q.push_back(e);
        end else if (dz) begin
            e.hi = model_hi; e.lo = model_lo; e.dbz = 1'b1;
            sb_q.push_back(e);
        end

        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'b110; a = $urandom; b = $urandom;

        if (iter) begin
            cyc = 0;
            while (busy === 1'b1 && cyc < 100) begin
                cyc++;
                if (cyc == intrude_at) begin
                    start = 1'b1; op = 3'b001; a = $urandom; b = $urandom;
                end
                if (cyc == reset_at) reset = 1'b1;
                @(negedge clk);
                start = 1'b0;
                if (reset) begin
                    reset = 1'b0;
                    break;
                end
            end
            if (reset_at != 0) begin
                model_hi = '0; model_lo = '0; model_dbz = 1'b0;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_hi", 64'(hi), 64'd0);
                check("abort_lo", 64'(lo), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                check("abort_dbz", 64'(div_by_zero), 64'd0);
            end else begin
                model_hi = r[63:32]; model_lo = r[31:0]; model_dbz = 1'b0;
                check("busy_cycles", 64'(cyc), 64'd33);
                check("done_after_busy", 64'(done), 64'd1);
                @(negedge clk);
                check("done_one_cycle", 64'(done), 64'd0);
            end
        end else if (dz) begin
            model_dbz = 1'b1;
            check("dz_busy", 64'(busy), 64'd0);
            check("dz_done", 64'(done), 64'd1);
            @(negedge clk);
            check("dz_busy_after", 64'(busy), 64'd0);
            check("dz_done_after", 64'(done), 64'd0);
        end else begin
            if (o == 3'd4) model_hi = x;
            if (o == 3'd5) model_lo = x;
            check("move_hi", 64'(hi), 64'(model_hi));
            check("move_lo", 64'(lo), 64'(model_lo));
            check("move_busy", 64'(busy), 64'd0);
            check("move_done", 64'(done), 64'd0);
            check("move_dbz", 64'(div_by_zero), 64'(model_dbz));
        end
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd0, -32'sd3, 32'd5);
        issue(3'd2, -32'sd7, 32'd2);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

        issue(3'd4, 32'h0000_1234, 32'd0);
        issue(3'd5, 32'h0000_1234, 32'd0);
        issue(3'd3, 32'd10, 32'd0);
        issue(3'd0, 32'd6, 32'd7);        // clears the sticky flag

        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5);

        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hAAAA_0000;
        @(negedge clk);
        op = 3'd5; a = 32'h0000_BBBB;
        @(negedge clk);
        start = 1'b0;
        model_hi = 32'hAAAA_0000; model_lo = 32'h0000_BBBB;
        check("mt_pair_hi", 64'(hi), 64'(model_hi));
        check("mt_pair_lo", 64'(lo), 64'(model_lo));
        check("mt_pair_busy", 64'(busy), 64'd0);
        check("mt_pair_done", 64'(done), 64'd0);

        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        issue(3'd7, 32'h3333_3333, 32'h0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 16));
                3: y = -32'($urandom_range(1, 16));
                default: ;
            endcase
            issue(o, x, y);
        end

        issue(3'd3, 32'd1000, 32'd7, 0, 10);
        repeat (40) @(negedge clk);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
